// File: rtl/control_pkg.sv
// Shared types and constants for the link command sequencer.
package control_pkg;

  typedef enum logic [2:0] {
    STARTUP      = 3'd0,
    WAIT_READY   = 3'd1,
    ISSUE        = 3'd2,
    WAIT_BUSY    = 3'd3,
    ADVANCE      = 3'd4,
    WAIT_RELEASE = 3'd5,
    DONE         = 3'd6
  } state_t;

  localparam logic CMD_1 = 1'b1;
  localparam logic CMD_2 = 1'b0;

  // Counter width able to hold 0..n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/control_edge_detect.sv
// Registers the serializer ready level and flags its rising edge.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic level_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      level    <= 1'b0;
      level_p1 <= 1'b0;
    end else begin
      level    <= din;
      level_p1 <= level;
    end
  end

  assign rise = level & ~level_p1;

endmodule

// File: rtl/control.sv
// Link command sequencer: issues one command 1 then NUM_CMDS-1 command 2
// to the serializer, paced by its ready handshake, then halts.
module control
  import control_pkg::*;
#(
  parameter int NUM_CMDS       = 5,
  parameter int STARTUP_CYCLES = 8,
  parameter int START_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  output logic command_1,
  output logic start,
  input  logic ready_command
);

  localparam int SW = cnt_w(STARTUP_CYCLES);
  localparam int PW = cnt_w(START_CYCLES);
  localparam int TW = cnt_w(TIMEOUT_CYCLES);
  localparam int IW = $clog2(NUM_CMDS + 1);

  localparam logic [SW-1:0] STARTUP_LAST = SW'((STARTUP_CYCLES > 0) ? STARTUP_CYCLES - 1 : 0);
  localparam logic [PW-1:0] PULSE_LAST   = PW'((START_CYCLES > 0) ? START_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_CMDS - 1);

  state_t        state, next_state;
  logic [SW-1:0] startup_cnt;
  logic [PW-1:0] pulse_cnt;
  logic [TW-1:0] timeout_cnt;
  logic [IW-1:0] cmd_idx;
  logic          ready_lvl, ready_rise;
  logic          start_d, command_1_d;

  edge_detect u_edge (
    .clk   (clk),
    .rst   (rst),
    .din   (ready_command),
    .level (ready_lvl),
    .rise  (ready_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= STARTUP;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      STARTUP:
        if (STARTUP_CYCLES == 0 || startup_cnt == STARTUP_LAST) next_state = WAIT_READY;
      WAIT_READY:
        if (ready_lvl) next_state = ISSUE;
      ISSUE:
        if (pulse_cnt == PULSE_LAST) next_state = WAIT_BUSY;
      WAIT_BUSY:
        if (!ready_lvl)                        next_state = ADVANCE;
        else if (timeout_cnt == TIMEOUT_LAST)  next_state = WAIT_READY;
      ADVANCE:
        next_state = (cmd_idx == IDX_LAST) ? DONE : WAIT_RELEASE;
      WAIT_RELEASE:
        if (ready_rise) next_state = ISSUE;
      DONE:
        next_state = DONE;
      default:
        next_state = STARTUP;
    endcase
  end

  // Command select only changes on entry to ISSUE or DONE, so it is stable for the whole pulse.
  always_comb begin
    start_d     = (next_state == ISSUE);
    command_1_d = command_1;
    if (state == WAIT_READY && next_state == ISSUE)
      command_1_d = (cmd_idx == '0) ? CMD_1 : CMD_2;
    else if (state == WAIT_RELEASE && next_state == ISSUE)
      command_1_d = CMD_2;
    else if (next_state == DONE)
      command_1_d = CMD_2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      startup_cnt <= '0;
      pulse_cnt   <= '0;
      timeout_cnt <= '0;
      cmd_idx     <= '0;
      start       <= 1'b0;
      command_1   <= CMD_1;
    end else begin
      startup_cnt <= (state == STARTUP) ? startup_cnt + 1'b1 : '0;
      pulse_cnt   <= (state == ISSUE && next_state == ISSUE) ? pulse_cnt + 1'b1 : '0;
      timeout_cnt <= (state == WAIT_BUSY && next_state == WAIT_BUSY) ? timeout_cnt + 1'b1 : '0;
      if (state == ADVANCE) cmd_idx <= cmd_idx + 1'b1;
      start       <= start_d;
      command_1   <= command_1_d;
    end
  end

endmodule

// File: tb/tb_control.sv
// Directed bench for the link command sequencer (default and 3-cycle pulse builds).
module tb_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ready_command = 1'b0;
  logic start, command_1, start3, command_1_3;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  control #(.NUM_CMDS(5), .STARTUP_CYCLES(8), .START_CYCLES(1), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst), .command_1(command_1), .start(start), .ready_command(ready_command)
  );

  control #(.NUM_CMDS(5), .STARTUP_CYCLES(8), .START_CYCLES(3), .TIMEOUT_CYCLES(255)) dut3 (
    .clk(clk), .rst(rst), .command_1(command_1_3), .start(start3), .ready_command(ready_command)
  );

  // Serializer-like ready: high 5 cycles, low 15, repeating.
  function automatic logic pat(input int c);
    return (c % 20) < 5;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    ready_command = rdy;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ready_command = i[0];
      tick();
      checks++;
      if (start !== 1'b0 || start3 !== 1'b0) begin
        errors++;
        $display("FAIL reset_start cycle %0d: got %b/%b expected 0/0", i, start, start3);
      end
      checks++;
      if (command_1 !== 1'b1 || command_1_3 !== 1'b1) begin
        errors++;
        $display("FAIL reset_cmd cycle %0d: got %b/%b expected 1/1", i, command_1, command_1_3);
      end
    end
  endtask

  task automatic test_nominal();
    int p = 0;
    int len = 0;
    logic prev = 1'b0;
    do_reset(1'b0);
    for (int c = 0; c < 300; c++) begin
      ready_command = pat(c);
      tick();
      if (start && !prev) begin
        checks++;
        if (command_1 !== (p == 0)) begin
          errors++;
          $display("FAIL nominal_cmd pulse %0d: got %b expected %b", p, command_1, (p == 0));
        end
        p++;
        len = 0;
      end
      if (start) len++;
      if (!start && prev) begin
        checks++;
        if (len !== 1) begin
          errors++;
          $display("FAIL nominal_width: got %0d expected 1", len);
        end
      end
      prev = start;
    end
    checks++;
    if (p !== 5) begin
      errors++;
      $display("FAIL nominal_count: got %0d expected 5", p);
    end
    checks++;
    if (command_1 !== 1'b0 || start !== 1'b0) begin
      errors++;
      $display("FAIL nominal_done: got cmd=%b start=%b expected cmd=0 start=0", command_1, start);
    end
  endtask

  task automatic test_startup();
    int first = -1;
    do_reset(1'b1);
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (start && first < 0) first = c;
    end
    checks++;
    if (first < 9 || first > 11) begin
      errors++;
      $display("FAIL startup_first: got cycle %0d expected 9..11", first);
    end
  endtask

  task automatic test_timeout();
    int p = 0, n1 = 0, n2 = 0, t0 = 0, t1 = 0;
    logic prev = 1'b0;
    logic cmd0 = 1'b0, cmd1 = 1'b0;
    do_reset(1'b1);
    for (int c = 0; c < 600; c++) begin
      ready_command = (c < 320) ? 1'b1 : pat(c - 320);
      tick();
      if (start && !prev) begin
        if (p == 0) begin t0 = c; cmd0 = command_1; end
        if (p == 1) begin t1 = c; cmd1 = command_1; end
        if (command_1) n1++;
        else           n2++;
        p++;
      end
      prev = start;
    end
    checks++;
    if (p < 2 || cmd0 !== 1'b1 || cmd1 !== 1'b1) begin
      errors++;
      $display("FAIL timeout_reissue: got pulses=%0d cmd0=%b cmd1=%b expected >=2,1,1", p, cmd0, cmd1);
    end
    checks++;
    if (t1 - t0 < 255 || t1 - t0 > 259) begin
      errors++;
      $display("FAIL timeout_gap: got %0d expected 255..259", t1 - t0);
    end
    checks++;
    if (n1 !== 2 || n2 !== 4) begin
      errors++;
      $display("FAIL timeout_total: got cmd1=%0d cmd2=%0d expected 2 and 4", n1, n2);
    end
  endtask

  task automatic test_mid_reset();
    int p = 0, n1 = 0, c = 0;
    logic prev = 1'b0;
    logic first_cmd = 1'b0;
    do_reset(1'b0);
    while (p < 3 && c < 200) begin
      ready_command = pat(c);
      tick();
      if (start && !prev) p++;
      prev = start;
      c++;
    end
    checks++;
    if (p !== 3) begin
      errors++;
      $display("FAIL midrst_reach: got %0d pulses expected 3", p);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (start !== 1'b0 || start3 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_start: got %b/%b expected 0/0", start, start3);
    end
    checks++;
    if (command_1 !== 1'b1 || command_1_3 !== 1'b1) begin
      errors++;
      $display("FAIL midrst_cmd: got %b/%b expected 1/1", command_1, command_1_3);
    end
    rst = 1'b0;
    p = 0;
    prev = 1'b0;
    for (int k = 0; k < 300; k++) begin
      ready_command = pat(k);
      tick();
      if (start && !prev) begin
        if (p == 0) first_cmd = command_1;
        if (command_1) n1++;
        p++;
      end
      prev = start;
    end
    checks++;
    if (p !== 5 || n1 !== 1 || first_cmd !== 1'b1) begin
      errors++;
      $display("FAIL midrst_restart: got pulses=%0d cmd1=%0d first=%b expected 5,1,1", p, n1, first_cmd);
    end
  endtask

  task automatic test_pulse_width();
    int p = 0;
    int len = 0;
    logic prev = 1'b0;
    logic cmd = 1'b0;
    do_reset(1'b0);
    for (int c = 0; c < 300; c++) begin
      ready_command = pat(c);
      tick();
      if (start3 && !prev) begin
        checks++;
        if (command_1_3 !== (p == 0)) begin
          errors++;
          $display("FAIL width_cmd pulse %0d: got %b expected %b", p, command_1_3, (p == 0));
        end
        cmd = command_1_3;
        len = 0;
        p++;
      end else if (start3 && prev) begin
        checks++;
        if (command_1_3 !== cmd) begin
          errors++;
          $display("FAIL width_stable: got %b expected %b", command_1_3, cmd);
        end
      end
      if (start3) len++;
      if (!start3 && prev) begin
        checks++;
        if (len !== 3) begin
          errors++;
          $display("FAIL width_len: got %0d expected 3", len);
        end
      end
      prev = start3;
    end
    checks++;
    if (p !== 5) begin
      errors++;
      $display("FAIL width_count: got %0d expected 5", p);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_startup();
    test_timeout();
    test_mid_reset();
    test_pulse_width();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
